// File: rtl/alu_result_stage.sv
// ALU result register stage: one-deep valid/ready pipeline slot with HI/LO.
// Optional HI/LO registers are enabled with `define HILO_EN.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid         - upstream ALU word valid
//   in_ready         - stage can accept this cycle
//   result, result2  - ALU primary and high results
//   equal            - ALU x==y flag
//   rd, reg_we       - destination register index and write enable
//   hilo_we          - load HI<=result2 and LO<=result on accept
//   mf_sel           - 01 move-from-HI, 10 move-from-LO, else pass result
//   flush            - drop held and incoming word
//   out_valid        - registered word valid
//   out_ready        - downstream accepts
//   out_data, out_rd, out_we, out_equal - registered word fields
//   hi, lo           - current HI/LO contents (zero without HILO_EN)
//   stall_cnt        - saturating count of out_valid && !out_ready cycles
module alu_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic [31:0] result2,
    input  logic        equal,
    input  logic [4:0]  rd,
    input  logic        reg_we,
    input  logic        hilo_we,
    input  logic [1:0]  mf_sel,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_equal,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] stall_cnt
);

    logic        accept;
    logic [31:0] sel_data;

    // Slot is free when empty or draining this cycle; flush is not in the
    // path so the handshake stays simple for upstream.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef HILO_EN
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (accept && hilo_we) begin
            hi_q <= result2;
            lo_q <= result;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    // Move-from reads the HI/LO values present before this edge.
    always_comb begin
        sel_data = result;
        unique case (mf_sel)
            2'b01:   sel_data = hi_q;
            2'b10:   sel_data = lo_q;
            default: sel_data = result;
        endcase
    end
`else
    logic unused_hilo;

    assign unused_hilo = ^{hilo_we, mf_sel, result2};
    assign hi          = '0;
    assign lo          = '0;
    assign sel_data    = result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            out_equal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_rd    <= rd;
            out_we    <= reg_we;
            out_equal <= equal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_alu_result_stage;

`ifdef HILO_EN
    localparam bit HE = 1'b1;
`else
    localparam bit HE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [31:0] result2;
    logic        equal;
    logic [4:0]  rd;
    logic        reg_we;
    logic        hilo_we;
    logic [1:0]  mf_sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_equal;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] stall_cnt;

    alu_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .result2   (result2),
        .equal     (equal),
        .rd        (rd),
        .reg_we    (reg_we),
        .hilo_we   (hilo_we),
        .mf_sel    (mf_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_equal (out_equal),
        .hi        (hi),
        .lo        (lo),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the visible stage state.
    logic        m_v;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        m_eq;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_st;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [31:0] r2;
        logic        eq;
        logic [4:0]  rd;
        logic        we;
        logic        hwe;
        logic [1:0]  mf;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_v;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_we;
        logic        e_eq;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [31:0] e_st;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_data = 0; m_rd = 0; m_we = 0; m_eq = 0;
        m_hi = 0; m_lo = 0; m_st = 0;
    endtask

    task automatic drive(input logic iv, input logic [31:0] res,
                         input logic [31:0] r2, input logic eq,
                         input logic [4:0] d, input logic we,
                         input logic hwe, input logic [1:0] mf,
                         input logic fl, input logic ordy);
        in_valid = iv; result = res; result2 = r2; equal = eq;
        rd = d; reg_we = we; hilo_we = hwe; mf_sel = mf;
        flush = fl; out_ready = ordy;
    endtask

    // One clock: check in_ready mid-cycle, advance model, sample after edge.
    task automatic do_cycle(input bit check_ir);
        logic        ir;
        logic        acc;
        logic [31:0] d;
        #3;
        ir  = !m_v || out_ready;
        acc = in_valid && ir && !flush;
        if (check_ir) chk("in_ready", {31'd0, in_ready}, {31'd0, ir});
        d = result;
        if (HE && mf_sel == 2'b01) d = m_hi;
        if (HE && mf_sel == 2'b10) d = m_lo;
        @(posedge clk);
        if (m_v && !out_ready && m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
        if (acc) begin
            m_v = 1; m_data = d; m_rd = rd; m_we = reg_we; m_eq = equal;
            if (HE && hilo_we) begin
                m_hi = result2;
                m_lo = result;
            end
        end else if (flush || out_ready) begin
            m_v = 0;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_v});
        chk({tag, ".out_data"}, out_data, m_data);
        chk({tag, ".out_rd"}, {27'd0, out_rd}, {27'd0, m_rd});
        chk({tag, ".out_we"}, {31'd0, out_we}, {31'd0, m_we});
        chk({tag, ".out_equal"}, {31'd0, out_equal}, {31'd0, m_eq});
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
        chk({tag, ".stall_cnt"}, stall_cnt, m_st);
    endtask

    function automatic vec_t mk(
        logic iv, logic [31:0] res, logic [31:0] r2, logic eq,
        logic [4:0] d, logic we, logic hwe, logic [1:0] mf, logic fl,
        logic ordy, logic e_ir, logic e_v, logic [31:0] e_data,
        logic [4:0] e_rd, logic e_we, logic e_eq, logic [31:0] e_hi,
        logic [31:0] e_lo, logic [31:0] e_st);
        vec_t v;
        v.iv = iv; v.res = res; v.r2 = r2; v.eq = eq; v.rd = d;
        v.we = we; v.hwe = hwe; v.mf = mf; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_v = e_v; v.e_data = e_data; v.e_rd = e_rd;
        v.e_we = e_we; v.e_eq = e_eq; v.e_hi = e_hi; v.e_lo = e_lo;
        v.e_st = e_st;
        return v;
    endfunction

    initial begin
        logic [31:0] xh;
        logic [31:0] xl;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [31:0] q[$];
        logic [31:0] ev;

        xh = HE ? 32'h0123_4567 : 32'h0;
        xl = HE ? 32'h89AB_CDEF : 32'h0;
        d2 = HE ? 32'h0123_4567 : 32'h11;
        d3 = HE ? 32'h89AB_CDEF : 32'h22;

        tbl[0]  = mk(1, 32'h5, 0, 0, 3, 1, 0, 0, 0, 1,
                     1, 1, 32'h5, 3, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h89AB_CDEF, 32'h0123_4567, 0, 4, 1, 1, 0, 0, 1,
                     1, 1, 32'h89AB_CDEF, 4, 1, 0, xh, xl, 0);
        tbl[2]  = mk(1, 32'h11, 0, 1, 5, 1, 0, 2'd1, 0, 1,
                     1, 1, d2, 5, 1, 1, xh, xl, 0);
        tbl[3]  = mk(1, 32'h22, 0, 0, 6, 1, 0, 2'd2, 0, 1,
                     1, 1, d3, 6, 1, 0, xh, xl, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 0, d3, 6, 1, 0, xh, xl, 0);
        tbl[5]  = mk(1, 32'h77, 0, 1, 7, 0, 0, 0, 0, 0,
                     1, 1, 32'h77, 7, 0, 1, xh, xl, 0);
        tbl[6]  = mk(1, 32'h99, 0, 0, 1, 1, 0, 0, 0, 0,
                     0, 1, 32'h77, 7, 0, 1, xh, xl, 1);
        tbl[7]  = mk(1, 32'h99, 0, 0, 1, 1, 0, 0, 0, 0,
                     0, 1, 32'h77, 7, 0, 1, xh, xl, 2);
        tbl[8]  = mk(1, 32'h99, 0, 0, 1, 1, 0, 0, 0, 0,
                     0, 1, 32'h77, 7, 0, 1, xh, xl, 3);
        tbl[9]  = mk(1, 32'h99, 0, 0, 1, 1, 0, 0, 0, 0,
                     0, 1, 32'h77, 7, 0, 1, xh, xl, 4);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     1, 0, 32'h77, 7, 0, 1, xh, xl, 4);
        tbl[11] = mk(1, 32'h55, 0, 0, 8, 1, 0, 0, 0, 1,
                     1, 1, 32'h55, 8, 1, 0, xh, xl, 4);
        tbl[12] = mk(1, 32'hAA, 32'hFFFF_FFFF, 0, 9, 1, 1, 0, 1, 1,
                     1, 0, 32'h55, 8, 1, 0, xh, xl, 4);
        tbl[13] = mk(1, 32'h66, 0, 0, 9, 1, 0, 0, 0, 0,
                     1, 1, 32'h66, 9, 1, 0, xh, xl, 4);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     0, 0, 32'h66, 9, 1, 0, xh, xl, 5);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_model("reset");
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].res, tbl[i].r2, tbl[i].eq, tbl[i].rd,
                  tbl[i].we, tbl[i].hwe, tbl[i].mf, tbl[i].fl, tbl[i].ordy);
            #3;
            chk($sformatf("t%0d.in_ready", i), {31'd0, in_ready},
                {31'd0, tbl[i].e_ir});
            #(-3 + 3);
            do_cycle(1'b0);
            chk($sformatf("t%0d.out_valid", i), {31'd0, out_valid},
                {31'd0, tbl[i].e_v});
            chk($sformatf("t%0d.out_data", i), out_data, tbl[i].e_data);
            chk($sformatf("t%0d.out_rd", i), {27'd0, out_rd},
                {27'd0, tbl[i].e_rd});
            chk($sformatf("t%0d.out_we", i), {31'd0, out_we},
                {31'd0, tbl[i].e_we});
            chk($sformatf("t%0d.out_equal", i), {31'd0, out_equal},
                {31'd0, tbl[i].e_eq});
            chk($sformatf("t%0d.hi", i), hi, tbl[i].e_hi);
            chk($sformatf("t%0d.lo", i), lo, tbl[i].e_lo);
            chk($sformatf("t%0d.stall_cnt", i), stall_cnt, tbl[i].e_st);
        end

        // Back-to-back words with a free downstream: no bubbles, in order.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + i, 0, 0, 5'(i), 1, 0, 0, 0, 1);
            q.push_back(32'h1000 + i);
            do_cycle(1'b1);
            ev = q.pop_front();
            chk("b2b.out_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b.out_data", out_data, ev);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_cycle(1'b1);
        chk("b2b.drain", {31'd0, out_valid}, 32'd0);

        // Reset asserted in the middle of a stall.
        drive(1, 32'h123, 32'h456, 1, 2, 1, 1, 0, 0, 0);
        do_cycle(1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1'b1);
        do_cycle(1'b1);
        chk_model("prestall");
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("rst_stall");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom), 5'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 2'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
            do_cycle(1'b1);
            chk_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: in_valid  input  1  upstream ALU word valid.
REQ-004 SHALL provide: in_ready  output  1  stage can accept this cycle.
REQ-005 SHALL provide: result  input  32  ALU low/primary result.
REQ-006 SHALL provide: result2  input  32  ALU high result (product high word or remainder).
REQ-007 SHALL provide: equal  input  1  ALU x==y flag.
REQ-008 SHALL provide: rd  input  5  destination register index.
REQ-009 SHALL provide: reg_we  input  1  destination write enable.
REQ-010 SHALL provide: hilo_we  input  1  write HI<=result2, LO<=result on accept.
REQ-011 SHALL provide: mf_sel  input  2  00 pass result, 01 move-from-HI, 10 move-from-LO, 11 pass result.
REQ-012 SHALL provide: flush  input  1  discard held and incoming word.
REQ-013 SHALL provide: out_valid  output  1  registered word valid.
REQ-014 SHALL provide: out_ready  input  1  downstream accepts.
REQ-015 SHALL provide: out_data  output  32; out_rd  output  5; out_we  output  1; out_equal  output  1.
REQ-016 SHALL provide: hi  output  32; lo  output  32  current HI/LO contents.
REQ-017 SHALL provide: stall_cnt  output  32  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinational, independent of flush.
REQ-019 Accept SHALL occur when in_valid && in_ready && !flush; latency input-to-out_valid is one cycle.
REQ-020 On accept: out_rd<=rd, out_we<=reg_we, out_equal<=equal, out_valid<=1.
REQ-021 On accept, out_data SHALL be HI (mf_sel=01), LO (mf_sel=10), else result, using HI/LO values before this edge.
REQ-022 On accept with hilo_we=1: HI<=result2, LO<=result at the same edge; a following move-from reads the new values.
REQ-023 No accept and out_ready=1: out_valid<=0; other out_* hold.
REQ-024 out_valid=1 and out_ready=0: all out_* SHALL hold stable (no overwrite).
REQ-025 flush=1: out_valid<=0 next edge, incoming word dropped, HI/LO and out_data unchanged.
REQ-026 Simultaneous accept and downstream drain SHALL replace the word with no bubble (full throughput).
REQ-027 stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready, saturating at 0xFFFFFFFF; flush does not clear it.

Reset
REQ-028 rst=1 SHALL immediately force out_valid=0, out_data=0, out_rd=0, out_we=0, out_equal=0, hi=0, lo=0, stall_cnt=0.
REQ-029 Reset mid-stall SHALL drop the held word; in_ready=1 from first cycle after reset release.

Configuration
REQ-030 Macro HILO_EN defined: HI/LO registers, hilo_we and mf_sel behaviour per REQ-021/022.
REQ-031 HILO_EN undefined: no HI/LO storage; hilo_we and mf_sel ignored; out_data=result on accept; hi=lo=0 constantly.

Verification
REQ-032 Reset, then result=0x00000005, rd=3, reg_we=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0x5, out_rd=3, out_we=1.
REQ-033 Accept result=0x89ABCDEF, result2=0x01234567, hilo_we=1; next word mf_sel=01 then mf_sel=10 -> out_data 0x01234567 then 0x89ABCDEF; hi/lo match (HILO_EN).
REQ-034 Hold out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, out_data stable, stall_cnt=4; release -> word drained, in_ready=1.
REQ-035 Back-to-back 8 words, out_ready=1 -> 8 consecutive out_valid cycles, no bubbles, order preserved.
REQ-036 flush with in_valid=1, hilo_we=1, result2=0xFFFFFFFF -> out_valid=0 next cycle, hi unchanged.
REQ-037 Assert rst during stall with out_valid=1 -> out_valid, hi, lo, stall_cnt read 0 before next clock edge.
